// File: rtl/btn_array.sv
// btn_array: NUM_BTN independent push-button debouncers, each with a clean level
// and one-cycle press, release, long-press and auto-repeat pulses.
module btn_array #(
    parameter int NUM_BTN      = 4,
    parameter int ACTIVE_LOW   = 1,
    parameter int DEBOUNCE_CNT = 80,
    parameter int LONG_CNT     = 50_000_000,
    parameter int REPEAT_EN    = 1,
    parameter int REPEAT_CNT   = 10_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] button_in,
    output logic [NUM_BTN-1:0] pressed,
    output logic [NUM_BTN-1:0] press_pulse,
    output logic [NUM_BTN-1:0] release_pulse,
    output logic [NUM_BTN-1:0] long_pulse,
    output logic [NUM_BTN-1:0] repeat_pulse
);
    localparam logic IDLE_LVL = (ACTIVE_LOW != 0);
    localparam int   DW       = $clog2(DEBOUNCE_CNT + 1);
    localparam int   HMAX     = (LONG_CNT > REPEAT_CNT) ? LONG_CNT : REPEAT_CNT;
    localparam int   HW       = $clog2(HMAX + 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CNT - 1);
    localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CNT - 1);
    localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CNT - 1);

    typedef enum logic [1:0] {RELEASED, HELD, LONG} hold_t;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        logic [1:0]    sync;
        logic          s, st, flip, press_ev, rel_ev;
        logic [DW-1:0] deb_cnt;
        hold_t         state, state_nx;
        logic [HW-1:0] hold_cnt, hold_nx;
        logic          long_nx, rep_nx;
        logic          pp, rp, lp, rpt;

        assign s        = sync[1] ^ IDLE_LVL;
        assign flip     = (s != st) && (deb_cnt == DEB_LAST);
        assign press_ev = flip && s;
        assign rel_ev   = flip && !s;

        // A release overrides any long/repeat that would fire on the same cycle.
        always_comb begin
            state_nx = state;
            hold_nx  = hold_cnt;
            long_nx  = 1'b0;
            rep_nx   = 1'b0;
            if (rel_ev) begin
                state_nx = RELEASED;
                hold_nx  = '0;
            end else if (state == RELEASED) begin
                state_nx = press_ev ? HELD : RELEASED;
                hold_nx  = '0;
            end else if (state == HELD) begin
                long_nx  = (hold_cnt == LONG_LAST);
                state_nx = long_nx ? LONG : HELD;
                hold_nx  = long_nx ? '0 : hold_cnt + 1'b1;
            end else if (REPEAT_EN != 0) begin
                rep_nx  = (hold_cnt == REP_LAST);
                hold_nx = rep_nx ? '0 : hold_cnt + 1'b1;
            end else begin
                hold_nx = '0;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync     <= {2{IDLE_LVL}};
                deb_cnt  <= '0;
                st       <= 1'b0;
                state    <= RELEASED;
                hold_cnt <= '0;
                pp       <= 1'b0;
                rp       <= 1'b0;
                lp       <= 1'b0;
                rpt      <= 1'b0;
            end else begin
                sync     <= {sync[0], button_in[i]};
                deb_cnt  <= (s == st || flip) ? '0 : deb_cnt + 1'b1;
                st       <= flip ? s : st;
                state    <= state_nx;
                hold_cnt <= hold_nx;
                pp       <= press_ev;
                rp       <= rel_ev;
                lp       <= long_nx;
                rpt      <= rep_nx;
            end
        end

        assign pressed[i]       = st;
        assign press_pulse[i]   = pp;
        assign release_pulse[i] = rp;
        assign long_pulse[i]    = lp;
        assign repeat_pulse[i]  = rpt;
    end
endmodule

// File: tb/tb_btn_array.sv
// tb_btn_array: directed and random checks of btn_array against a window/timer
// model of the debounce and hold rules.
module tb_btn_array;
    localparam int NB  = 2;
    localparam int D   = 4;
    localparam int L   = 10;
    localparam int REN = 1;
    localparam int R   = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] button_in = '1;
    logic [NB-1:0] pressed, press_pulse, release_pulse, long_pulse, repeat_pulse;

    int passed = 0;
    int total  = 0;

    btn_array #(
        .NUM_BTN(NB), .ACTIVE_LOW(1), .DEBOUNCE_CNT(D),
        .LONG_CNT(L), .REPEAT_EN(REN), .REPEAT_CNT(R)
    ) dut (
        .clk(clk), .rst(rst), .button_in(button_in), .pressed(pressed),
        .press_pulse(press_pulse), .release_pulse(release_pulse),
        .long_pulse(long_pulse), .repeat_pulse(repeat_pulse)
    );

    always #5 clk = ~clk;

    // Model: pressed flips once the last D synchronised samples all disagree with it;
    // hold events come from the cycle count since the press.
    logic [1:0]    dly  [NB];
    logic [D-1:0]  hist [NB];
    logic [NB-1:0] m_st, e_pp, e_rp, e_lp, e_rep;
    logic          sv   [NB];
    bit            held [NB];
    int            t    [NB];

    always @(posedge clk or posedge rst) begin
        for (int c = 0; c < NB; c++) begin
            if (rst) begin
                dly[c]   = 2'b11;
                hist[c]  = '0;
                m_st[c]  = 1'b0;
                held[c]  = 1'b0;
                t[c]     = 0;
                e_pp[c]  = 1'b0;
                e_rp[c]  = 1'b0;
                e_lp[c]  = 1'b0;
                e_rep[c] = 1'b0;
            end else begin
                sv[c]    = !dly[c][1];
                dly[c]   = {dly[c][0], button_in[c]};
                hist[c]  = {hist[c][D-2:0], sv[c]};
                e_pp[c]  = 1'b0;
                e_rp[c]  = 1'b0;
                e_lp[c]  = 1'b0;
                e_rep[c] = 1'b0;
                if (hist[c] == (m_st[c] ? {D{1'b0}} : {D{1'b1}})) begin
                    m_st[c] = sv[c];
                    e_pp[c] = sv[c];
                    e_rp[c] = !sv[c];
                    held[c] = sv[c];
                    t[c]    = 0;
                end else if (held[c]) begin
                    t[c]++;
                    e_lp[c]  = (t[c] == L);
                    e_rep[c] = (REN != 0) && (t[c] > L) && ((t[c] - L) % R == 0);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [NB-1:0] got, input logic [NB-1:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
        else passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("pressed", pressed, m_st);
            chk("press_pulse", press_pulse, e_pp);
            chk("release_pulse", release_pulse, e_rp);
            chk("long_pulse", long_pulse, e_lp);
            chk("repeat_pulse", repeat_pulse, e_rep);
        end
    end

    initial begin
        repeat (3) tick();
        chk("rst_pressed", pressed, 2'b00);
        chk("rst_pulses", press_pulse | release_pulse | long_pulse | repeat_pulse, 2'b00);
        rst = 1'b0;
        repeat (3) tick();
        // press ch0; P = E+5 where E is the next edge
        button_in[0] = 1'b0;
        repeat (5) tick();
        chk("deb_early", pressed, 2'b00);
        tick();
        chk("press_lat", pressed, 2'b01);
        chk("press_edge", press_pulse, 2'b01);
        tick();
        chk("press_1cyc", press_pulse, 2'b00);
        repeat (9) tick();
        chk("long_at_10", long_pulse, 2'b01);
        tick();
        chk("long_1cyc", long_pulse, 2'b00);
        repeat (4) tick();
        chk("rep_at_15", repeat_pulse, 2'b01);
        repeat (5) tick();
        chk("rep_at_20", repeat_pulse, 2'b01);
        repeat (9) tick();
        button_in[0] = 1'b1;
        repeat (6) tick();
        chk("rel_on_rep", release_pulse, 2'b01);
        chk("rep_suppressed", repeat_pulse, 2'b00);
        button_in[0] = 1'b0;
        repeat (6) tick();
        chk("repress", press_pulse, 2'b01);
        repeat (10) tick();
        chk("relong", long_pulse, 2'b01);
        button_in[0] = 1'b1;
        repeat (10) tick();
        // bounce: 3 low / 1 high never completes a window of 4
        for (int k = 0; k < 4; k++) begin
            button_in[0] = 1'b0;
            repeat (3) tick();
            button_in[0] = 1'b1;
            tick();
        end
        chk("bounce_ignored", pressed, 2'b00);
        button_in[0] = 1'b0;
        repeat (5) tick();
        chk("bounce_hold_early", pressed, 2'b00);
        tick();
        chk("bounce_hold_press", pressed, 2'b01);
        button_in[0] = 1'b1;
        repeat (10) tick();
        // two channels two cycles apart
        button_in[0] = 1'b0;
        repeat (2) tick();
        button_in[1] = 1'b0;
        repeat (4) tick();
        chk("two_ch0_press", press_pulse, 2'b01);
        repeat (2) tick();
        chk("two_ch1_press", press_pulse, 2'b10);
        repeat (8) tick();
        chk("two_ch0_long", long_pulse, 2'b01);
        repeat (2) tick();
        chk("two_ch1_long", long_pulse, 2'b10);
        button_in[1] = 1'b1;
        repeat (6) tick();
        chk("two_ch1_rel", release_pulse, 2'b10);
        chk("two_ch0_held", pressed, 2'b01);
        repeat (2) tick();
        chk("two_ch0_rep", repeat_pulse, 2'b01);
        button_in[0] = 1'b1;
        repeat (10) tick();
        // reset while ch1 is in LONG, pin kept low across reset
        button_in[1] = 1'b0;
        repeat (20) tick();
        #1;
        rst = 1'b1;
        #1;
        chk("rst_async_pressed", pressed, 2'b00);
        chk("rst_async_pulses", press_pulse | release_pulse | long_pulse | repeat_pulse, 2'b00);
        repeat (2) tick();
        #1;
        rst = 1'b0;
        repeat (5) tick();
        chk("post_rst_early", press_pulse, 2'b00);
        tick();
        chk("post_rst_press", press_pulse, 2'b10);
        // random pin activity with rare resets
        repeat (3000) begin
            tick();
            for (int c = 0; c < NB; c++)
                if ($urandom_range(0, 11) == 0) button_in[c] = !button_in[c];
            if ($urandom_range(0, 999) == 0) begin
                #1;
                rst = 1'b1;
                tick();
                #1;
                rst = 1'b0;
            end
        end
        tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
